// File: rtl/tdc_pkt_pkg.sv
// tdc_pkt_pkg: packet constants, packet kinds and FSM encoding shared with the host decoder
package tdc_pkt_pkg;
  localparam logic [7:0] SYNC_BYTE = 8'hA5;
  localparam logic [7:0] DATA_TAG = 8'h44;
  localparam logic [7:0] LINE_TAG = 8'h4C;
  localparam logic [7:0] FRAME_TAG = 8'h46;
  localparam int DATA_PKT_LEN = 9;
  localparam int MARK_PKT_LEN = 3;
  typedef enum logic [2:0] {IDLE, POP, LATCH, SEND, GAP, WAIT} state_t;
  typedef enum logic [1:0] {PKT_DATA, PKT_LINE, PKT_FRAME} pkt_t;
  function automatic logic [7:0] pkt_tag(pkt_t k);
    return k == PKT_FRAME ? FRAME_TAG : k == PKT_LINE ? LINE_TAG : DATA_TAG;
  endfunction
  function automatic logic [3:0] last_idx(pkt_t k);
    return k == PKT_DATA ? 4'(DATA_PKT_LEN - 1) : 4'(MARK_PKT_LEN - 1);
  endfunction
endpackage

// File: rtl/tdc_packet_serializer_if.sv
// tdc_packet_serializer_if: FIFO, marker request and serial_tx byte signals of the serializer
interface tdc_packet_serializer_if;
  logic [47:0] fifo_dout;
  logic fifo_empty;
  logic fifo_rd_en;
  logic new_line;
  logic new_frame;
  logic line_done;
  logic frame_done;
  logic [7:0] tx_data;
  logic new_tx_data;
  logic tx_busy;
  logic busy;
  modport master (
    input fifo_dout, fifo_empty, new_line, new_frame, tx_busy,
    output fifo_rd_en, line_done, frame_done, tx_data, new_tx_data, busy
  );
  modport slave (
    output fifo_dout, fifo_empty, new_line, new_frame, tx_busy,
    input fifo_rd_en, line_done, frame_done, tx_data, new_tx_data, busy
  );
endinterface

// File: rtl/pkt_byte_sel.sv
// pkt_byte_sel: picks the outgoing byte from byte index and packet kind
module pkt_byte_sel
  import tdc_pkt_pkg::*;
(
  input  logic [3:0] idx,
  input  pkt_t       kind,
  input  logic [7:0] word_byte,
  input  logic [7:0] chk,
  output logic [7:0] tx_byte
);
  always_comb begin
    tx_byte = idx == 4'd0 ? SYNC_BYTE :
              idx == 4'd1 ? pkt_tag(kind) :
              idx == last_idx(kind) ? chk : word_byte;
  end
endmodule

// File: rtl/tdc_packet_serializer.sv
// tdc_packet_serializer: frames FIFO words and line/frame markers into checksummed byte packets
module tdc_packet_serializer
  import tdc_pkt_pkg::*;
(
  input logic clk,
  input logic rst_n,
  tdc_packet_serializer_if.master bus
);
  state_t state;
  pkt_t kind;
  logic [3:0] idx;
  logic [47:0] sr;
  logic [7:0] chk;
  logic [7:0] cur;
  logic line_pend;
  logic frame_pend;
  logic last;
  pkt_byte_sel u_sel (.idx(idx), .kind(kind), .word_byte(sr[47:40]), .chk(chk), .tx_byte(cur));
  assign last = idx == last_idx(kind);
  assign bus.busy = state != IDLE || line_pend || frame_pend;
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
      kind <= PKT_DATA;
      idx <= '0;
      sr <= '0;
      chk <= '0;
      line_pend <= 1'b0;
      frame_pend <= 1'b0;
      bus.fifo_rd_en <= 1'b0;
      bus.new_tx_data <= 1'b0;
      bus.tx_data <= '0;
      bus.line_done <= 1'b0;
      bus.frame_done <= 1'b0;
    end else begin
      bus.fifo_rd_en <= 1'b0;
      bus.new_tx_data <= 1'b0;
      bus.line_done <= 1'b0;
      bus.frame_done <= 1'b0;
      line_pend <= line_pend | bus.new_line;
      frame_pend <= frame_pend | bus.new_frame;
      case (state)
        IDLE: begin
          idx <= '0;
          if (frame_pend) begin
            kind <= PKT_FRAME;
            chk <= FRAME_TAG;
            frame_pend <= bus.new_frame;
            state <= SEND;
          end else if (line_pend) begin
            kind <= PKT_LINE;
            chk <= LINE_TAG;
            line_pend <= bus.new_line;
            state <= SEND;
          end else if (!bus.fifo_empty) begin
            kind <= PKT_DATA;
            bus.fifo_rd_en <= 1'b1;
            state <= POP;
          end
        end
        POP: state <= LATCH;
        // fifo_dout is valid in this cycle, one cycle after the pop strobe
        LATCH: begin
          sr <= bus.fifo_dout;
          chk <= DATA_TAG;
          state <= SEND;
        end
        SEND: if (!bus.tx_busy) begin
          bus.tx_data <= cur;
          bus.new_tx_data <= 1'b1;
          if (idx >= 4'd2 && !last) begin
            chk <= chk ^ cur;
            sr <= sr << 8;
          end
          bus.line_done <= last && kind == PKT_LINE;
          bus.frame_done <= last && kind == PKT_FRAME;
          state <= GAP;
        end
        // serial_tx raises tx_busy one cycle after the strobe, so skip one cycle
        GAP: state <= WAIT;
        WAIT: if (!bus.tx_busy) begin
          idx <= idx + 4'd1;
          state <= last ? IDLE : SEND;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_tdc_packet_serializer.sv
// tb_tdc_packet_serializer: directed and randomized checks against a byte-stream reference model
module tb_tdc_packet_serializer;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #10 clk = ~clk;
  tdc_packet_serializer_if bus ();
  tdc_packet_serializer dut (.clk(clk), .rst_n(rst_n), .bus(bus));
  int total = 0;
  int bad = 0;
  logic [47:0] fifo_q[$];
  logic [7:0] got[$];
  logic [7:0] exp_q[$];
  logic [7:0] done_seq[$];
  int byte_time = 10;
  int cnt = 0;
  logic force_busy = 1'b0;
  int rd_cnt = 0;
  int line_cnt = 0;
  int frame_cnt = 0;
  int rd_when_empty = 0;
  int done_misaligned = 0;
  assign bus.tx_busy = force_busy || cnt != 0;
  always @(posedge clk) begin
    if (bus.fifo_rd_en === 1'b1 && fifo_q.size() > 0) bus.fifo_dout <= fifo_q.pop_front();
    bus.fifo_empty <= fifo_q.size() == 0;
    if (bus.new_tx_data === 1'b1) cnt <= byte_time;
    else if (cnt > 0) cnt <= cnt - 1;
  end
  always @(negedge clk) begin
    if (bus.new_tx_data === 1'b1) got.push_back(bus.tx_data);
    if (bus.fifo_rd_en === 1'b1) begin
      rd_cnt++;
      if (bus.fifo_empty === 1'b1) rd_when_empty++;
    end
    if (bus.line_done === 1'b1) begin
      line_cnt++;
      done_seq.push_back("L");
      if (bus.new_tx_data !== 1'b1) done_misaligned++;
    end
    if (bus.frame_done === 1'b1) begin
      frame_cnt++;
      done_seq.push_back("F");
      if (bus.new_tx_data !== 1'b1) done_misaligned++;
    end
  end
  task automatic tick(int n = 1);
    repeat (n) @(negedge clk);
  endtask
  task automatic chk(string tag, logic [63:0] obs, logic [63:0] exp_v);
    total++;
    assert (obs === exp_v) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp_v);
    end
  endtask
  function automatic void add_data(logic [47:0] w);
    logic [7:0] c;
    logic [7:0] b;
    c = 8'h44;
    exp_q.push_back(8'hA5);
    exp_q.push_back(8'h44);
    for (int i = 5; i >= 0; i--) begin
      b = w[i*8 +: 8];
      c ^= b;
      exp_q.push_back(b);
    end
    exp_q.push_back(c);
  endfunction
  function automatic void add_mark(logic [7:0] tag);
    exp_q.push_back(8'hA5);
    exp_q.push_back(tag);
    exp_q.push_back(tag);
  endfunction
  task automatic clear_counts();
    rd_cnt = 0;
    line_cnt = 0;
    frame_cnt = 0;
    done_seq.delete();
  endtask
  task automatic wait_idle(string tag, int limit);
    int n = 0;
    tick(2);
    while ((bus.busy !== 1'b0 || fifo_q.size() > 0 || bus.fifo_empty !== 1'b1) && n < limit) begin
      tick();
      n++;
    end
    chk({tag, "_idle"}, 64'(n < limit), 64'(1));
  endtask
  task automatic wait_got(string tag, int n);
    int k = 0;
    while (got.size() < n && k < 5000) begin
      tick();
      k++;
    end
    chk({tag, "_reach"}, 64'(got.size() >= n), 64'(1));
  endtask
  task automatic cmp_stream(string tag);
    chk({tag, "_len"}, 64'(got.size()), 64'(exp_q.size()));
    for (int i = 0; i < exp_q.size() && i < got.size(); i++)
      chk($sformatf("%s_b%0d", tag, i), 64'(got[i]), 64'(exp_q[i]));
    got.delete();
    exp_q.delete();
  endtask
  initial begin
    logic [47:0] w;
    logic [7:0] held;
    int n;
    int f;
    int l;
    int nw;
    bus.new_line = 1'b0;
    bus.new_frame = 1'b0;
    fifo_q.push_back(48'h0123_4567_89AB);
    repeat (3) begin
      tick();
      chk("rst_rd_en", 64'(bus.fifo_rd_en), 64'(0));
      chk("rst_new_tx", 64'(bus.new_tx_data), 64'(0));
      chk("rst_busy", 64'(bus.busy), 64'(0));
    end
    rst_n = 1'b1;
    add_data(48'h0123_4567_89AB);
    wait_idle("t2", 3000);
    cmp_stream("t2");
    chk("t2_pops", 64'(rd_cnt), 64'(1));
    clear_counts();
    bus.new_line = 1'b1;
    bus.new_frame = 1'b1;
    tick();
    bus.new_line = 1'b0;
    bus.new_frame = 1'b0;
    add_mark(8'h46);
    add_mark(8'h4C);
    wait_idle("t3", 2000);
    cmp_stream("t3");
    chk("t3_done_n", 64'(done_seq.size()), 64'(2));
    if (done_seq.size() == 2) begin
      chk("t3_first", 64'(done_seq[0]), 64'("F"));
      chk("t3_second", 64'(done_seq[1]), 64'("L"));
    end
    clear_counts();
    w = {$urandom(), $urandom()} >> 16;
    fifo_q.push_back(w);
    add_data(w);
    wait_got("t4a", 3);
    bus.new_line = 1'b1;
    tick();
    bus.new_line = 1'b0;
    wait_got("t4b", 6);
    bus.new_line = 1'b1;
    tick();
    bus.new_line = 1'b0;
    add_mark(8'h4C);
    wait_idle("t4", 3000);
    cmp_stream("t4");
    chk("t4_line_done", 64'(line_cnt), 64'(1));
    chk("t4_pops", 64'(rd_cnt), 64'(1));
    clear_counts();
    w = {$urandom(), $urandom()} >> 16;
    fifo_q.push_back(w);
    add_data(w);
    wait_got("t5", 4);
    force_busy = 1'b1;
    n = got.size();
    held = bus.tx_data;
    tick(500);
    chk("t5_no_strobe", 64'(got.size()), 64'(n));
    chk("t5_tx_hold", 64'(bus.tx_data), 64'(held));
    force_busy = 1'b0;
    wait_idle("t5", 3000);
    cmp_stream("t5");
    clear_counts();
    w = {$urandom(), $urandom()} >> 16;
    fifo_q.push_back(w);
    add_data(w);
    wait_got("t6", 5);
    rst_n = 1'b0;
    tick(3);
    while (exp_q.size() > 5) void'(exp_q.pop_back());
    chk("t6_busy", 64'(bus.busy), 64'(0));
    rst_n = 1'b1;
    tick(30);
    cmp_stream("t6_cut");
    chk("t6_no_done", 64'(line_cnt + frame_cnt), 64'(0));
    w = {$urandom(), $urandom()} >> 16;
    fifo_q.push_back(w);
    add_data(w);
    wait_idle("t6r", 3000);
    cmp_stream("t6_next");
    for (int it = 0; it < 8; it++) begin
      clear_counts();
      byte_time = $urandom_range(2, 12);
      f = $urandom_range(0, 1);
      l = $urandom_range(0, 1);
      nw = $urandom_range(0, 2);
      if (f + l + nw == 0) nw = 1;
      bus.new_frame = f[0];
      bus.new_line = l[0];
      if (f != 0) add_mark(8'h46);
      if (l != 0) add_mark(8'h4C);
      for (int k = 0; k < nw; k++) begin
        w = {$urandom(), $urandom()} >> 16;
        fifo_q.push_back(w);
        add_data(w);
      end
      tick();
      bus.new_frame = 1'b0;
      bus.new_line = 1'b0;
      wait_idle($sformatf("rnd%0d", it), 6000);
      cmp_stream($sformatf("rnd%0d", it));
      chk($sformatf("rnd%0d_pops", it), 64'(rd_cnt), 64'(nw));
      chk($sformatf("rnd%0d_dones", it), 64'(line_cnt + frame_cnt), 64'(f + l));
    end
    chk("rd_while_empty", 64'(rd_when_empty), 64'(0));
    chk("done_alignment", 64'(done_misaligned), 64'(0));
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
